qq_cmd_frontend: RTL and testbench

Command front-end for the QuickQ priority queue, sitting directly upstream of the queue control FSM. It accepts enqueue/dequeue commands over a valid/ready interface and buffers them in a small FIFO. It issues them one at a time to the controller as single-cycle `enq`/`deq` pulses, waits for completion, and returns one response per command. Commands that would enqueue into a full queue, dequeue from an empty queue, or get no completion from the controller are answered with an error.

---
 rtl/qq_pkg.sv | 6 +
 rtl/qq_cmd_frontend_if.sv | 17 +
 rtl/qq_cmd_fifo.sv | 32 +++
 rtl/qq_cmd_frontend.sv | 92 +++++++++
 tb/tb_qq_cmd_frontend.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/qq_pkg.sv
// qq_pkg: shared types and defaults for the QuickQ command front-end
package qq_pkg;
  localparam int DATA_W = 32;
  typedef enum logic {OP_ENQ = 1'b0, OP_DEQ = 1'b1} op_t;
  typedef enum logic [2:0] {IDLE, CHECK, ISSUE, WAIT, RESP} fe_state_t;
endpackage

// File: rtl/qq_cmd_frontend_if.sv
// qq_cmd_frontend_if: command, controller and response signals of the front-end
interface qq_cmd_frontend_if #(parameter int DATA_W = qq_pkg::DATA_W);
  logic              cmd_valid, cmd_ready, cmd_op;
  logic [DATA_W-1:0] cmd_data;
  logic              enq, deq, done, full, empty;
  logic [DATA_W-1:0] din, dout;
  logic              rsp_valid, rsp_ready, rsp_err, busy;
  logic [DATA_W-1:0] rsp_data;
  modport slave (
    input  cmd_valid, cmd_op, cmd_data, done, full, empty, dout, rsp_ready,
    output cmd_ready, enq, deq, din, rsp_valid, rsp_data, rsp_err, busy
  );
  modport master (
    output cmd_valid, cmd_op, cmd_data, done, full, empty, dout, rsp_ready,
    input  cmd_ready, enq, deq, din, rsp_valid, rsp_data, rsp_err, busy
  );
endinterface

// File: rtl/qq_cmd_fifo.sv
// qq_cmd_fifo: circular command buffer with registered occupancy count
module qq_cmd_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_push,
  input  logic                    i_pop,
  input  logic [W-1:0]            i_data,
  output logic [W-1:0]            o_head,
  output logic [$clog2(DEPTH):0]  o_count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  assign o_head = r_mem[r_rd_ptr];
  // payload storage; contents are don't-care until pushed, so no reset
  always_ff @(posedge clk)
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  // pointers wrap naturally; simultaneous push and pop keep the count
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      o_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      o_count <= o_count + (AW+1)'(i_push) - (AW+1)'(i_pop);
    end
endmodule

// File: rtl/qq_cmd_frontend.sv
// qq_cmd_frontend: buffers queue commands and issues them one at a time to the controller
module qq_cmd_frontend #(
  parameter int DATA_W  = qq_pkg::DATA_W,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input logic              clk,
  input logic              rst,
  qq_cmd_frontend_if.slave bus
);
  import qq_pkg::*;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT);
  fe_state_t         r_state;
  op_t               r_cur_op;
  logic [DATA_W-1:0] r_cur_data;
  logic [TW-1:0]     r_timer;
  logic [CW-1:0]     w_count;
  logic [DATA_W:0]   w_head;
  logic              w_push, w_pop;
  assign w_push        = bus.cmd_valid && bus.cmd_ready;
  assign w_pop         = (r_state == IDLE) && (w_count != '0);
  assign bus.cmd_ready = w_count != CW'(DEPTH);
  assign bus.busy      = (r_state != IDLE) || (w_count != '0);
  qq_cmd_fifo #(.W(DATA_W + 1), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  ({bus.cmd_op, bus.cmd_data}),
    .o_head  (w_head),
    .o_count (w_count)
  );
  // command sequencer: fetch, status check, one-cycle issue, wait for done, respond
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state       <= IDLE;
      r_cur_op      <= OP_ENQ;
      r_cur_data    <= '0;
      r_timer       <= '0;
      bus.enq       <= 1'b0;
      bus.deq       <= 1'b0;
      bus.din       <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      bus.enq <= 1'b0;
      bus.deq <= 1'b0;
      case (r_state)
        IDLE:
          if (w_pop) begin
            r_cur_op   <= op_t'(w_head[DATA_W]);
            r_cur_data <= w_head[DATA_W-1:0];
            r_state    <= CHECK;
          end
        CHECK:
          if ((r_cur_op == OP_ENQ && bus.full) || (r_cur_op == OP_DEQ && bus.empty)) begin
            bus.rsp_err   <= 1'b1;
            bus.rsp_data  <= '0;
            bus.rsp_valid <= 1'b1;
            r_state       <= RESP;
          end else begin
            bus.enq <= r_cur_op == OP_ENQ;
            bus.deq <= r_cur_op == OP_DEQ;
            bus.din <= r_cur_data;
            r_state <= ISSUE;
          end
        ISSUE, WAIT:
          if (bus.done) begin
            bus.rsp_data  <= (r_cur_op == OP_DEQ) ? bus.dout : '0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_valid <= 1'b1;
            r_state       <= RESP;
          end else if (r_state == WAIT && r_timer == TW'(TIMEOUT - 1)) begin
            bus.rsp_data  <= '0;
            bus.rsp_err   <= 1'b1;
            bus.rsp_valid <= 1'b1;
            r_state       <= RESP;
          end else begin
            r_timer <= (r_state == ISSUE) ? '0 : r_timer + 1'b1;
            r_state <= WAIT;
          end
        RESP:
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            r_state       <= IDLE;
          end
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_qq_cmd_frontend.sv
// tb_qq_cmd_frontend: directed scenarios with hand-computed expectations
module tb_qq_cmd_frontend;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int enq_cnt = 0;
  int deq_cnt = 0;
  logic [32:0] log_q[$];
  always #5 clk = ~clk;
  qq_cmd_frontend_if #(.DATA_W(32)) bus ();
  qq_cmd_frontend #(.DATA_W(32), .DEPTH(4), .TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
  // record every controller request as {is_deq, din}
  always @(posedge clk) begin
    if (bus.enq) enq_cnt <= enq_cnt + 1;
    if (bus.deq) deq_cnt <= deq_cnt + 1;
    if (bus.enq || bus.deq) log_q.push_back({bus.deq, bus.din});
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic op, input logic [31:0] d);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = d;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic ack();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    cyc(2);
    rst = 1'b0;
    cyc(1);
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %0b exp 1", bus.cmd_ready); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", bus.busy); end
    checks++; if ({bus.enq, bus.deq, bus.rsp_valid, bus.rsp_err} !== 4'b0) begin errors++; $display("FAIL reset_ctrl got %b exp 0000", {bus.enq, bus.deq, bus.rsp_valid, bus.rsp_err}); end
    checks++; if ({bus.din, bus.rsp_data} !== 64'h0) begin errors++; $display("FAIL reset_data got din=%h rsp_data=%h exp 0", bus.din, bus.rsp_data); end
  endtask

  task automatic test_enqueue();
    int e0 = enq_cnt;
    push(1'b0, 32'h10);
    cyc(2);
    checks++; if (bus.enq !== 1'b1 || bus.din !== 32'h10) begin errors++; $display("FAIL enq_issue got enq=%0b din=%h exp 1 10", bus.enq, bus.din); end
    cyc(4);
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL enq_early_rsp got %0b exp 0", bus.rsp_valid); end
    bus.done = 1'b1;
    cyc(1);
    bus.done = 1'b0;
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0 || bus.rsp_data !== 32'h0) begin errors++; $display("FAIL enq_rsp got v=%0b err=%0b data=%h exp 1 0 0", bus.rsp_valid, bus.rsp_err, bus.rsp_data); end
    checks++; if (enq_cnt - e0 !== 1) begin errors++; $display("FAIL enq_pulses got %0d exp 1", enq_cnt - e0); end
    checks++; if (bus.din !== 32'h10) begin errors++; $display("FAIL enq_din_hold got %h exp 10", bus.din); end
    ack();
    checks++; if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL enq_release got v=%0b busy=%0b exp 0 0", bus.rsp_valid, bus.busy); end
  endtask

  task automatic test_dequeue();
    int d0 = deq_cnt;
    push(1'b1, 32'hDEAD);
    cyc(2);
    checks++; if (bus.deq !== 1'b1 || bus.enq !== 1'b0) begin errors++; $display("FAIL deq_issue got deq=%0b enq=%0b exp 1 0", bus.deq, bus.enq); end
    bus.done = 1'b1;
    bus.dout = 32'h2A;
    cyc(1);
    bus.done = 1'b0;
    bus.dout = 32'h55;
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0 || bus.rsp_data !== 32'h2A) begin errors++; $display("FAIL deq_rsp got v=%0b err=%0b data=%h exp 1 0 2a", bus.rsp_valid, bus.rsp_err, bus.rsp_data); end
    cyc(1);
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h2A) begin errors++; $display("FAIL deq_hold got v=%0b data=%h exp 1 2a", bus.rsp_valid, bus.rsp_data); end
    checks++; if (deq_cnt - d0 !== 1) begin errors++; $display("FAIL deq_pulses got %0d exp 1", deq_cnt - d0); end
    ack();
  endtask

  task automatic test_reject();
    int e0 = enq_cnt;
    int d0 = deq_cnt;
    bus.empty = 1'b1;
    push(1'b1, 32'h0);
    cyc(1);
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rej_deq_early got %0b exp 0", bus.rsp_valid); end
    cyc(1);
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_data !== 32'h0) begin errors++; $display("FAIL rej_deq_rsp got v=%0b err=%0b data=%h exp 1 1 0", bus.rsp_valid, bus.rsp_err, bus.rsp_data); end
    ack();
    bus.empty = 1'b0;
    bus.full  = 1'b1;
    push(1'b0, 32'h77);
    cyc(2);
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_data !== 32'h0) begin errors++; $display("FAIL rej_enq_rsp got v=%0b err=%0b data=%h exp 1 1 0", bus.rsp_valid, bus.rsp_err, bus.rsp_data); end
    ack();
    bus.full = 1'b0;
    checks++; if (enq_cnt - e0 !== 0 || deq_cnt - d0 !== 0) begin errors++; $display("FAIL rej_pulses got enq=%0d deq=%0d exp 0 0", enq_cnt - e0, deq_cnt - d0); end
  endtask

  task automatic test_timeout();
    push(1'b0, 32'h5);
    cyc(18);
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL tmo_early got %0b exp 0", bus.rsp_valid); end
    cyc(1);
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_data !== 32'h0) begin errors++; $display("FAIL tmo_rsp got v=%0b err=%0b data=%h exp 1 1 0", bus.rsp_valid, bus.rsp_err, bus.rsp_data); end
    ack();
    checks++; if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL tmo_idle got busy=%0b v=%0b exp 0 0", bus.busy, bus.rsp_valid); end
  endtask

  task automatic test_back_to_back();
    logic [4:0] opv = 5'b10010;
    int l0 = log_q.size();
    int n;
    for (int i = 0; i < 5; i++) push(opv[i], 32'hA0 + 32'(i));
    checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready got %0b exp 0", bus.cmd_ready); end
    cyc(3);
    checks++; if (bus.cmd_ready !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_stall got ready=%0b busy=%0b exp 0 1", bus.cmd_ready, bus.busy); end
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        n = 0;
        while (!(bus.enq || bus.deq) && n < 40) begin @(negedge clk); n++; end
        checks++; if (n >= 40) begin errors++; $display("FAIL b2b_issue_%0d got no request in 40 cycles exp request", i); end
        bus.done = 1'b1;
        bus.dout = 32'hD0 + 32'(i);
        @(negedge clk);
        bus.done = 1'b0;
      end
      n = 0;
      while (!bus.rsp_valid && n < 40) begin @(negedge clk); n++; end
      checks++; if (bus.rsp_err !== (i == 0) || bus.rsp_data !== ((i > 0 && opv[i]) ? 32'hD0 + 32'(i) : 32'h0)) begin errors++; $display("FAIL b2b_rsp_%0d got v=%0b err=%0b data=%h", i, bus.rsp_valid, bus.rsp_err, bus.rsp_data); end
      @(negedge clk);
    end
    bus.rsp_ready = 1'b0;
    checks++; if (log_q.size() - l0 !== 5) begin errors++; $display("FAIL b2b_issued got %0d exp 5", log_q.size() - l0); end
    for (int i = 0; i < 5 && l0 + i < log_q.size(); i++) begin
      checks++; if (log_q[l0+i][32] !== opv[i] || (!opv[i] && log_q[l0+i][31:0] !== 32'hA0 + 32'(i))) begin errors++; $display("FAIL b2b_order_%0d got %h exp op=%0b data=%h", i, log_q[l0+i], opv[i], 32'hA0 + 32'(i)); end
    end
    checks++; if (bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_drained got busy=%0b ready=%0b exp 0 1", bus.busy, bus.cmd_ready); end
  endtask

  task automatic test_reset_mid();
    int l0;
    int seen = 0;
    push(1'b0, 32'hB0);
    push(1'b1, 32'hB1);
    push(1'b0, 32'hB2);
    cyc(2);
    checks++; if (bus.busy !== 1'b1 || bus.din !== 32'hB0) begin errors++; $display("FAIL rstm_inflight got busy=%0b din=%h exp 1 b0", bus.busy, bus.din); end
    rst = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rstm_async got busy=%0b ready=%0b v=%0b exp 0 1 0", bus.busy, bus.cmd_ready, bus.rsp_valid); end
    checks++; if (bus.din !== 32'h0 || bus.enq !== 1'b0 || bus.deq !== 1'b0) begin errors++; $display("FAIL rstm_outs got din=%h enq=%0b deq=%0b exp 0 0 0", bus.din, bus.enq, bus.deq); end
    @(negedge clk);
    rst = 1'b0;
    l0 = log_q.size();
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) seen++;
    end
    checks++; if (seen !== 0 || log_q.size() !== l0) begin errors++; $display("FAIL rstm_quiet got rsp=%0d issues=%0d exp 0 0", seen, log_q.size() - l0); end
    checks++; if (bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL rstm_idle got busy=%0b ready=%0b exp 0 1", bus.busy, bus.cmd_ready); end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 1'b0;
    bus.cmd_data  = '0;
    bus.done      = 1'b0;
    bus.full      = 1'b0;
    bus.empty     = 1'b0;
    bus.dout      = '0;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_enqueue();
    test_dequeue();
    test_reject();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
